// File: rtl/param_cpu_pkg.sv
// Shared constants for the parametrised operand-register CPU slice.
// Op-code values and FSM state encoding used by the core and its ALU.
// No logic; import with param_cpu_pkg::*.
package param_cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_MOV = 4'hC;
    localparam logic [3:0] OP_INC = 4'hD;
    localparam logic [3:0] OP_DEC = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] WB   = 2'b10;

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational 16-op ALU for the CPU slice.
// Latency: zero (pure combinational), no handshake.
// Every subtract-like op shares a single (DATA_W+1)-bit adder.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic              cin,
    input  logic              carry_flag,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              wr_en,
    output logic              carry_upd
);

    logic [DATA_W-1:0] add_b;
    logic              add_c;
    logic [DATA_W:0]   sum;

    // Adder operand selection: subtraction is A + ~B + carry-in, DEC adds all-ones
    always_comb begin
        add_b = b;
        add_c = 1'b0;
        case (op)
            OP_ADC:         add_c = cin;
            OP_SUB, OP_CMP: begin add_b = ~b; add_c = 1'b1; end
            OP_SBC:         begin add_b = ~b; add_c = cin;  end
            OP_INC:         begin add_b = '0; add_c = 1'b1; end
            OP_DEC:         begin add_b = '1; add_c = 1'b0; end
            default:        ;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_c};

    // Result/carry mux; logic ops and MOV leave the carry flag alone
    always_comb begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        carry_upd = 1'b1;
        wr_en     = (op != OP_CMP);
        case (op)
            OP_AND: begin result = a & b; carry_upd = 1'b0; end
            OP_OR:  begin result = a | b; carry_upd = 1'b0; end
            OP_XOR: begin result = a ^ b; carry_upd = 1'b0; end
            OP_NOT: begin result = ~a;    carry_upd = 1'b0; end
            OP_MOV: begin result = b;     carry_upd = 1'b0; end
            OP_SHL: begin result = {a[DATA_W-2:0], 1'b0};       carry_out = a[DATA_W-1]; end
            OP_SHR: begin result = {1'b0, a[DATA_W-1:1]};       carry_out = a[0];        end
            OP_ROL: begin result = {a[DATA_W-2:0], carry_flag}; carry_out = a[DATA_W-1]; end
            OP_ROR: begin result = {carry_flag, a[DATA_W-1:1]}; carry_out = a[0];        end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_cpu_core.sv
// Register-file CPU slice: loads in one cycle, ALU ops in IDLE->EXEC->WB.
// Latency: done 2 cycles after accept; next accept 3 cycles after the previous.
// Backpressure: cmd_ready only in IDLE; commands held by the master until accepted.
// Optional debug read port: define PARAM_CPU_CORE_DBG_RDPORT_EN.
module param_cpu_core
    import param_cpu_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  REG_N  = 8,
    localparam int SEL_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [3:0]        cmd_op,
    input  logic              cmd_cin,
    input  logic [DATA_W-1:0] data_in,
`ifdef PARAM_CPU_CORE_DBG_RDPORT_EN
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              busy,
    output logic              done
);

    logic [1:0]        state;
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        op_q;
    logic              cin_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_wr_en;
    logic              alu_carry_upd;
    logic              accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state == EXEC) || (state == WB);
    assign done      = (state == WB);
    assign data_out  = regs[0];

`ifdef PARAM_CPU_CORE_DBG_RDPORT_EN
    assign dbg_data = regs[dbg_sel];
`endif

    param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .op         (op_q),
        .cin        (cin_q),
        .carry_flag (carry_flag),
        .result     (alu_result),
        .carry_out  (alu_carry),
        .wr_en      (alu_wr_en),
        .carry_upd  (alu_carry_upd)
    );

    // FSM, register file, operand latches and flags; reset aborts any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_load) begin
                            regs[cmd_sel] <= data_in;
                        end else begin
                            a_q   <= regs[0];
                            b_q   <= regs[cmd_sel];
                            op_q  <= cmd_op;
                            cin_q <= cmd_cin;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (alu_wr_en) begin
                        regs[0] <= alu_result;
                    end
                    if (alu_carry_upd) begin
                        carry_flag <= alu_carry;
                    end
                    zero_flag <= (alu_result == '0);
                    state     <= WB;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
